// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the MEM stage and a debug port,
// alternating grants under contention, range-checking addresses and counting accesses.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_ack,
  output logic             dbg_err,
  output logic [31:0]      dbg_rdata,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] cpu_cnt,
  output logic [CNT_W-1:0] dbg_cnt
);
  typedef enum logic [1:0] {IDLE, G_CPU, G_DBG} state_t;
  state_t state, state_nx;
  logic own_cpu, own_dbg, go, we, inr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cpu_cnt <= '0;
      dbg_cnt <= '0;
    end else begin
      state <= state_nx;
      if (cpu_ack && !cpu_err && !(&cpu_cnt)) cpu_cnt <= cpu_cnt + CNT_W'(1);
      if (dbg_ack && !dbg_err && !(&dbg_cnt)) dbg_cnt <= dbg_cnt + CNT_W'(1);
    end
  end
  // the current owner is excluded from the next grant, so contention alternates
  always_comb begin
    state_nx  = (state != G_CPU && cpu_req) ? G_CPU : (state != G_DBG && dbg_req) ? G_DBG : IDLE;
    own_cpu   = state == G_CPU;
    own_dbg   = state == G_DBG;
    mem_addr  = own_cpu ? cpu_addr : own_dbg ? dbg_addr : 32'h0;
    mem_wdata = own_cpu ? cpu_wdata : own_dbg ? dbg_wdata : 32'h0;
    we        = own_dbg ? dbg_we : cpu_we;
    inr       = mem_addr < 32'(DEPTH);
    go        = rst_n && ((own_cpu && cpu_req) || (own_dbg && dbg_req));
    mem_rd    = go && !we && inr;
    mem_wr    = go && we && inr;
    cpu_ack   = go && own_cpu;
    dbg_ack   = go && own_dbg;
    cpu_err   = cpu_ack && !inr;
    dbg_err   = dbg_ack && !inr;
    cpu_rdata = (cpu_ack && mem_rd) ? mem_rdata : 32'h0;
    dbg_rdata = (dbg_ack && mem_rd) ? mem_rdata : 32'h0;
    cpu_stall = cpu_req && !cpu_ack;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table for the directed scenarios, then random traffic
// checked against a turn-taking reference model with its own memory image.
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_rd, mem_wr;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] cpu_cnt, dbg_cnt;
  logic [31:0] env_mem [64];
  logic s_req, s_ack, s_err, s_stall, s_dack, s_derr, s_mrd, s_mwr;
  logic [31:0] s_rdata, s_drdata, s_maddr, s_mwdata;
  logic [31:0] s_mem_rdata = 32'h0;
  logic [1:0] s_cnt, s_dcnt;

  dmem_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_cnt(cpu_cnt), .dbg_cnt(dbg_cnt)
  );

  dmem_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_ack(s_ack), .cpu_err(s_err), .cpu_rdata(s_rdata), .cpu_stall(s_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
    .dbg_ack(s_dack), .dbg_err(s_derr), .dbg_rdata(s_drdata),
    .mem_rd(s_mrd), .mem_wr(s_mwr), .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_rdata(s_mem_rdata), .cpu_cnt(s_cnt), .dbg_cnt(s_dcnt)
  );

  // memory that ignores upper address bits, so a stray enable shows up as corruption
  assign mem_rdata = env_mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_wr) env_mem[mem_addr[5:0]] <= mem_wdata;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  int m_own = 0, m_cc = 0, m_dc = 0;
  logic [31:0] ref_mem [64];
  logic e_cack, e_cerr, e_dack, e_derr, e_mrd, e_mwr;
  logic [31:0] e_crd, e_drd, e_addr, e_wd;
  bit mchk = 0;

  task automatic eval_model();
    logic oreq, owe, go, inr;
    oreq   = m_own == 1 ? cpu_req : m_own == 2 ? dbg_req : 1'b0;
    owe    = m_own == 1 ? cpu_we : dbg_we;
    e_addr = m_own == 1 ? cpu_addr : dbg_addr;
    e_wd   = m_own == 1 ? cpu_wdata : dbg_wdata;
    inr    = e_addr < 64;
    go     = rst_n && oreq;
    e_cack = go && m_own == 1;
    e_dack = go && m_own == 2;
    e_cerr = e_cack && !inr;
    e_derr = e_dack && !inr;
    e_mrd  = go && !owe && inr;
    e_mwr  = go && owe && inr;
    e_crd  = (e_cack && e_mrd) ? ref_mem[e_addr[5:0]] : 32'h0;
    e_drd  = (e_dack && e_mrd) ? ref_mem[e_addr[5:0]] : 32'h0;
  endtask

  task automatic cmp_model();
    chk("m_flags", {cpu_ack, cpu_err, dbg_ack, dbg_err, mem_rd, mem_wr, cpu_stall},
        {e_cack, e_cerr, e_dack, e_derr, e_mrd, e_mwr, cpu_req && !e_cack});
    chk("m_crd", cpu_rdata, e_crd);
    chk("m_drd", dbg_rdata, e_drd);
    if (e_mrd || e_mwr) chk("m_maddr", mem_addr, e_addr);
    if (e_mwr) chk("m_mwdata", mem_wdata, e_wd);
    chk("m_ccnt", cpu_cnt, m_cc);
    chk("m_dcnt", dbg_cnt, m_dc);
  endtask

  // next owner: a requester that did not own the previous cycle, cpu preferred
  task automatic upd_model();
    if (!rst_n) begin
      m_own = 0; m_cc = 0; m_dc = 0;
    end else begin
      if (e_mwr) ref_mem[e_addr[5:0]] = e_wd;
      if (e_cack && !e_cerr) m_cc = m_cc < 65535 ? m_cc + 1 : 65535;
      if (e_dack && !e_derr) m_dc = m_dc < 65535 ? m_dc + 1 : 65535;
      m_own = (cpu_req && m_own != 1) ? 1 : (dbg_req && m_own != 2) ? 2 : 0;
    end
  endtask

  task automatic half();
    @(negedge clk);
    eval_model();
    if (mchk) cmp_model();
  endtask

  task automatic fin();
    @(posedge clk);
    upd_model();
    #1;
  endtask

  typedef struct {
    logic rst, cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic [6:0] fl; logic [31:0] crd, drd, ma; int cc, dc;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic rst, cr, cw, input logic [31:0] ca, cd,
                              input logic dr, dw, input logic [31:0] da, dd,
                              input logic [6:0] fl, input logic [31:0] crd, drd, ma,
                              input int cc, dc);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.fl = fl; v.crd = crd; v.drd = drd; v.ma = ma; v.cc = cc; v.dc = dc;
    return v;
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      0: return 32'd64 + $urandom_range(0, 200);
      1: return 32'hFFFF_FFC0 | $urandom_range(0, 63);
      2: return 32'h0001_0000 | $urandom_range(0, 63);
      default: return $urandom_range(0, 63);
    endcase
  endfunction

  initial begin
    logic [7:0] pat, sp;
    int acks;
    for (int i = 0; i < 64; i++) begin env_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    {cpu_req, cpu_we, dbg_req, dbg_we, s_req} = '0;
    {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
    // flags: {cpu_ack, cpu_err, dbg_ack, dbg_err, mem_rd, mem_wr, cpu_stall}
    tv.push_back(mk(1, 1,1,5,'h2A, 0,0,0,0, 7'b0000001, 0,0,0, 0,0));
    tv.push_back(mk(1, 1,1,5,'h2A, 0,0,0,0, 7'b1000010, 0,0,5, 0,0));
    tv.push_back(mk(1, 1,0,5,0,    0,0,0,0, 7'b0000001, 0,0,0, 1,0));
    tv.push_back(mk(1, 1,0,5,0,    0,0,0,0, 7'b1000100, 'h2A,0,5, 1,0));
    tv.push_back(mk(1, 0,0,0,0,    0,0,0,0, 7'b0000000, 0,0,0, 2,0));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b0000001, 0,0,0, 2,0));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b1000100, 'h2A,0,5, 2,0));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b0010101, 0,'h2A,5, 3,0));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b1000100, 'h2A,0,5, 3,1));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b0010101, 0,'h2A,5, 4,1));
    tv.push_back(mk(1, 1,0,5,0,    1,0,5,0, 7'b1000100, 'h2A,0,5, 4,2));
    tv.push_back(mk(1, 0,0,0,0,    1,0,5,0, 7'b0010100, 0,'h2A,5, 5,2));
    tv.push_back(mk(1, 0,0,0,0,    0,0,0,0, 7'b0000000, 0,0,0, 5,3));
    tv.push_back(mk(1, 0,0,0,0,    1,1,64,'hFF, 7'b0000000, 0,0,0, 5,3));
    tv.push_back(mk(1, 0,0,0,0,    1,1,64,'hFF, 7'b0011000, 0,0,0, 5,3));
    tv.push_back(mk(1, 0,0,0,0,    0,0,0,0, 7'b0000000, 0,0,0, 5,3));
    tv.push_back(mk(1, 0,0,0,0,    1,1,9,'h55, 7'b0000000, 0,0,0, 5,3));
    tv.push_back(mk(0, 0,0,0,0,    1,1,9,'h55, 7'b0000000, 0,0,0, 5,3));
    tv.push_back(mk(1, 0,0,0,0,    0,0,0,0, 7'b0000000, 0,0,0, 0,0));
    #1;
    repeat (2) begin half(); fin(); end
    foreach (tv[i]) begin
      rst_n = tv[i].rst; cpu_req = tv[i].cr; cpu_we = tv[i].cw; cpu_addr = tv[i].ca;
      cpu_wdata = tv[i].cd; dbg_req = tv[i].dr; dbg_we = tv[i].dw; dbg_addr = tv[i].da;
      dbg_wdata = tv[i].dd;
      half();
      chk($sformatf("v%0d_flags", i),
          {cpu_ack, cpu_err, dbg_ack, dbg_err, mem_rd, mem_wr, cpu_stall}, tv[i].fl);
      chk($sformatf("v%0d_crd", i), cpu_rdata, tv[i].crd);
      chk($sformatf("v%0d_drd", i), dbg_rdata, tv[i].drd);
      if (tv[i].fl[2] || tv[i].fl[1]) chk($sformatf("v%0d_maddr", i), mem_addr, tv[i].ma);
      chk($sformatf("v%0d_ccnt", i), cpu_cnt, tv[i].cc);
      chk($sformatf("v%0d_dcnt", i), dbg_cnt, tv[i].dc);
      fin();
    end
    chk("mem5_written", env_mem[5], 32'h2A);
    chk("mem0_untouched", env_mem[0], 32'h0);
    chk("mem9_reset_write", env_mem[9], 32'h0);
    // lone cpu requester held: grants every other cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 5;
    for (int i = 0; i < 8; i++) begin
      half(); pat[i] = cpu_ack; sp[i] = cpu_stall; fin();
    end
    cpu_req = 0;
    half();
    chk("hold_ack_pattern", pat, 8'b10101010);
    chk("hold_stall_pattern", sp, 8'b01010101);
    chk("hold_cnt", cpu_cnt, 4);
    fin();
    // saturation on the 2-bit counter build
    s_req = 1; acks = 0;
    for (int i = 0; i < 10; i++) begin half(); acks += s_ack; fin(); end
    s_req = 0;
    half();
    chk("sat_acks", acks, 5);
    chk("sat_cnt", s_cnt, 3);
    fin();
    s_req = 1;
    repeat (4) begin half(); fin(); end
    s_req = 0;
    half();
    chk("sat_hold", s_cnt, 3);
    fin();
    mchk = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 63) != 0;
      cpu_req = $urandom_range(0, 2) != 0; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rnd_addr(); cpu_wdata = $urandom();
      dbg_req = $urandom_range(0, 2) != 0; dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = rnd_addr(); dbg_wdata = $urandom();
      half(); fin();
    end
    mchk = 0;
    for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), env_mem[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
